// File: rtl/vram_server.sv
// vram_server: slot-locked arbiter for one external 16-bit async SRAM.
// Serves the video controller's paired word fetch in the ALT slot of each
// 8-slot pixel group, and single CPU byte accesses in the fixed CPU slot
// (or in the ALT slot when no video fetch is active for the group).
// All SRAM-facing state advances only on ce_24m (four ticks per slot).
// The only exception is cpu_ack, which is a one clk_sys wide pulse.
module vram_server #(
    parameter logic [2:0] CPU_SLOT = 3'd5,
    parameter logic [2:0] ALT_SLOT = 3'd1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_24m,
    input  logic [2:0]  slot,
    input  logic        fetch,
    input  logic [18:0] vram_addr1,
    input  logic [18:0] vram_addr2,
    output logic [15:0] vram_dout1,
    output logic [15:0] vram_dout2,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [18:0] sram_addr,
    input  logic [15:0] sram_dq_i,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VRD1   = 3'd1,
        VRD2   = 3'd2,
        CPU_RD = 3'd3,
        CPU_WR = 3'd4
    } state_t;

    state_t      state, state_nx;

    // Slot tracking: sub counts ticks spent in the current slot.
    logic [2:0]  slot_q;
    logic [1:0]  sub, sub_nx;
    logic        slot_new;

    // Grant decisions, evaluated only while IDLE on the slot's sub==0 tick.
    logic        grant_video;
    logic        grant_cpu;

    // Datapath registers and their next values.
    logic [18:0] addr2_q, addr2_nx;
    logic [15:0] buf1, buf1_nx;
    logic [15:0] buf2, buf2_nx;
    logic        upd_pend, upd_nx;
    logic        byte_hi, byte_hi_nx;
    logic [15:0] dout1_nx, dout2_nx;
    logic [7:0]  rdata_nx;
    logic [18:0] addr_nx;
    logic [15:0] dq_o_nx;
    logic        dq_oe_nx;
    logic        we_n_nx;
    logic        oe_n_nx;
    logic        ub_n_nx;
    logic        lb_n_nx;
    logic        ack_nx;

    // Tick counter within a slot, saturating so long slots never wrap to 0.
    function automatic logic [1:0] sub_sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    // Pick the addressed byte lane out of an SRAM word.
    function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    // Slot-change detection and grant qualification.
    always_comb begin
        slot_new    = (slot != slot_q);
        sub_nx      = slot_new ? 2'd0 : sub_sat_inc(sub);
        grant_video = (slot == ALT_SLOT) && (sub == 2'd0) && fetch;
        grant_cpu   = (sub == 2'd0) && cpu_req &&
                      ((slot == CPU_SLOT) || ((slot == ALT_SLOT) && !fetch));
    end

    // State register; advances only on access ticks.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ce_24m) begin
            state <= state_nx;
        end
    end

    // Next-state and next-output logic; idle strobe levels are the defaults.
    always_comb begin
        state_nx   = state;
        addr2_nx   = addr2_q;
        buf1_nx    = buf1;
        buf2_nx    = buf2;
        upd_nx     = upd_pend;
        byte_hi_nx = byte_hi;
        dout1_nx   = vram_dout1;
        dout2_nx   = vram_dout2;
        rdata_nx   = cpu_rdata;
        addr_nx    = sram_addr;
        dq_o_nx    = sram_dq_o;
        dq_oe_nx   = 1'b0;
        we_n_nx    = 1'b1;
        oe_n_nx    = 1'b1;
        ub_n_nx    = 1'b1;
        lb_n_nx    = 1'b1;
        ack_nx     = 1'b0;

        // Both video words are published together on the first tick of the
        // slot after the fetch, so the controller never sees a torn pair.
        if (upd_pend && slot_new) begin
            dout1_nx = buf1;
            dout2_nx = buf2;
            upd_nx   = 1'b0;
        end

        case (state)
            IDLE: begin
                if (grant_video) begin
                    state_nx = VRD1;
                    addr_nx  = vram_addr1;
                    addr2_nx = vram_addr2;
                    oe_n_nx  = 1'b0;
                    ub_n_nx  = 1'b0;
                    lb_n_nx  = 1'b0;
                end else if (grant_cpu) begin
                    addr_nx    = cpu_addr[19:1];
                    byte_hi_nx = cpu_addr[0];
                    ub_n_nx    = ~cpu_addr[0];
                    lb_n_nx    = cpu_addr[0];
                    if (cpu_we) begin
                        state_nx = CPU_WR;
                        dq_o_nx  = {cpu_wdata, cpu_wdata};
                        dq_oe_nx = 1'b1;
                        we_n_nx  = 1'b0;
                    end else begin
                        state_nx = CPU_RD;
                        oe_n_nx  = 1'b0;
                    end
                end
            end
            VRD1: begin
                state_nx = VRD2;
                buf1_nx  = sram_dq_i;
                addr_nx  = addr2_q;
                oe_n_nx  = 1'b0;
                ub_n_nx  = 1'b0;
                lb_n_nx  = 1'b0;
            end
            VRD2: begin
                state_nx = IDLE;
                buf2_nx  = sram_dq_i;
                upd_nx   = 1'b1;
            end
            CPU_RD: begin
                state_nx = IDLE;
                rdata_nx = lane_sel(sram_dq_i, byte_hi);
                ack_nx   = 1'b1;
            end
            CPU_WR: begin
                // Data stays driven one tick past the we_n rising edge for hold.
                state_nx = IDLE;
                dq_oe_nx = 1'b1;
                ack_nx   = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Slot tracking, buffers and SRAM-facing outputs, all on access ticks.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= 3'd0;
            sub        <= 2'd0;
            addr2_q    <= 19'd0;
            buf1       <= 16'd0;
            buf2       <= 16'd0;
            upd_pend   <= 1'b0;
            byte_hi    <= 1'b0;
            vram_dout1 <= 16'd0;
            vram_dout2 <= 16'd0;
            cpu_rdata  <= 8'd0;
            sram_addr  <= 19'd0;
            sram_dq_o  <= 16'd0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else if (ce_24m) begin
            slot_q     <= slot;
            sub        <= sub_nx;
            addr2_q    <= addr2_nx;
            buf1       <= buf1_nx;
            buf2       <= buf2_nx;
            upd_pend   <= upd_nx;
            byte_hi    <= byte_hi_nx;
            vram_dout1 <= dout1_nx;
            vram_dout2 <= dout2_nx;
            cpu_rdata  <= rdata_nx;
            sram_addr  <= addr_nx;
            sram_dq_o  <= dq_o_nx;
            sram_dq_oe <= dq_oe_nx;
            sram_we_n  <= we_n_nx;
            sram_oe_n  <= oe_n_nx;
            sram_ub_n  <= ub_n_nx;
            sram_lb_n  <= lb_n_nx;
        end
    end

    // Completion pulse: set on the finishing tick, cleared on the next clock.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack <= 1'b0;
        end else begin
            cpu_ack <= ce_24m && ack_nx;
        end
    end

endmodule

// File: tb/tb_vram_server.sv
// tb_vram_server: directed bench for vram_server with a small SRAM model.
// One access tick = two clk_sys cycles (ce_24m high for one of them), one
// slot = four ticks, so a strobe held for N ticks is low for 2*N clocks.
module tb_vram_server;

    logic        clk_sys;
    logic        reset_n;
    logic        ce_24m;
    logic [2:0]  slot;
    logic        fetch;
    logic [18:0] vram_addr1;
    logic [18:0] vram_addr2;
    logic [15:0] vram_dout1;
    logic [15:0] vram_dout2;
    logic        cpu_req;
    logic        cpu_we;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [18:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int n_tests = 0;
    int n_fail  = 0;

    vram_server dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_24m     (ce_24m),
        .slot       (slot),
        .fetch      (fetch),
        .vram_addr1 (vram_addr1),
        .vram_addr2 (vram_addr2),
        .vram_dout1 (vram_dout1),
        .vram_dout2 (vram_dout2),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // SRAM model: 64K words is enough for the addresses used here.
    logic [15:0] mem [0:65535];
    logic        mem_load;

    assign sram_dq_i = !sram_oe_n ? mem[sram_addr[15:0]] : 16'h0000;

    always @(posedge clk_sys) begin
        if (mem_load) begin
            mem[16'h0010] <= 16'h1234;
            mem[16'h6010] <= 16'hABCD;
        end else if (!sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[15:0]][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_addr[15:0]][7:0]  <= sram_dq_o[7:0];
        end
    end

    // Bus monitor: running totals that tests difference against snapshots.
    int         ack_total = 0;
    int         oe_clks   = 0;
    int         we_clks   = 0;
    int         viol      = 0;
    logic [2:0] ack_slot  = 3'd0;
    logic [7:0] ack_rdata = 8'd0;
    logic       we_ub     = 1'b1;
    logic       we_lb     = 1'b1;

    always @(negedge clk_sys) begin
        if (cpu_ack) begin
            ack_total <= ack_total + 1;
            ack_slot  <= slot;
            ack_rdata <= cpu_rdata;
        end
        if (!sram_oe_n) oe_clks <= oe_clks + 1;
        if (!sram_we_n) begin
            we_clks <= we_clks + 1;
            we_ub   <= sram_ub_n;
            we_lb   <= sram_lb_n;
        end
        if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n)) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access tick; the CPU side drops its request once it sees the ack.
    task automatic tick();
        ce_24m = 1'b1;
        @(posedge clk_sys); #1;
        if (cpu_ack) cpu_req = 1'b0;
        ce_24m = 1'b0;
        @(posedge clk_sys); #1;
        if (cpu_ack) cpu_req = 1'b0;
    endtask

    task automatic run_slot(input logic [2:0] s);
        slot = s;
        repeat (4) tick();
    endtask

    task automatic cpu_start(input logic we, input logic [19:0] a, input logic [7:0] d);
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_req   = 1'b1;
    endtask

    int b_oe, b_ack, b_we;

    initial begin
        reset_n = 1'b0; ce_24m = 1'b0; slot = 3'd0; fetch = 1'b0;
        vram_addr1 = 19'd0; vram_addr2 = 19'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 20'd0; cpu_wdata = 8'd0;
        mem_load = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        mem_load = 1'b0;

        // Reset values
        check("rst_dout1", {16'd0, vram_dout1}, 32'h0);
        check("rst_dout2", {16'd0, vram_dout2}, 32'h0);
        check("rst_ack_rdata", {23'd0, cpu_ack, cpu_rdata}, 32'h0);
        check("rst_addr_dq", {13'd0, sram_addr}, 32'h0);
        check("rst_dq_o_oe", {15'd0, sram_dq_oe, sram_dq_o}, 32'h0);
        check("rst_strobes", {28'd0, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'hF);
        reset_n = 1'b1;

        // Video fetch group: two reads in slot 1, published at slot 2
        fetch = 1'b1; vram_addr1 = 19'h00010; vram_addr2 = 19'h06010;
        run_slot(3'd0);
        b_oe = oe_clks;
        run_slot(3'd1);
        check("vid_oe_clks", oe_clks - b_oe, 4);
        check("vid_dout1_not_yet", {16'd0, vram_dout1}, 32'h0);
        run_slot(3'd2);
        check("vid_dout1_s2", {16'd0, vram_dout1}, 32'h1234);
        check("vid_dout2_s2", {16'd0, vram_dout2}, 32'hABCD);
        run_slot(3'd3);
        run_slot(3'd4);
        check("vid_dout_s4", {vram_dout1, vram_dout2}, 32'h1234ABCD);
        for (int s = 5; s < 8; s++) run_slot(3'(s));

        // fetch=0 group: no reads, outputs held even with a new address
        fetch = 1'b0; vram_addr1 = 19'h06010;
        b_oe = oe_clks;
        for (int s = 0; s < 8; s++) run_slot(3'(s));
        check("nofetch_oe_clks", oe_clks - b_oe, 0);
        check("nofetch_dout_held", {vram_dout1, vram_dout2}, 32'h1234ABCD);

        // CPU write 0x5A to byte 0x00021 (high lane of word 0x10) at slot 5
        fetch = 1'b1; vram_addr1 = 19'h00010;
        for (int s = 0; s < 5; s++) run_slot(3'(s));
        b_ack = ack_total; b_we = we_clks;
        cpu_start(1'b1, 20'h00021, 8'h5A);
        run_slot(3'd5);
        check("wr_we_clks", we_clks - b_we, 2);
        check("wr_lanes", {30'd0, we_ub, we_lb}, 32'h1);
        check("wr_ack_count", ack_total - b_ack, 1);
        check("wr_ack_slot", {29'd0, ack_slot}, 32'd5);
        check("wr_mem_word", {16'd0, mem[16'h0010]}, 32'h5A34);
        check("wr_dq_oe_released", {31'd0, sram_dq_oe}, 32'h0);
        run_slot(3'd6); run_slot(3'd7);

        // Readback requested at slot 1 with fetch=1: video first, CPU at slot 5
        run_slot(3'd0);
        b_ack = ack_total; b_oe = oe_clks;
        cpu_start(1'b0, 20'h00021, 8'h00);
        run_slot(3'd1);
        check("rb_s1_oe_video_only", oe_clks - b_oe, 4);
        for (int s = 2; s < 5; s++) run_slot(3'(s));
        check("rb_no_ack_before_s5", ack_total - b_ack, 0);
        check("rb_refetch_dout1", {16'd0, vram_dout1}, 32'h5A34);
        run_slot(3'd5);
        check("rb_ack_count", ack_total - b_ack, 1);
        check("rb_ack_slot", {29'd0, ack_slot}, 32'd5);
        check("rb_rdata_hi", {24'd0, ack_rdata}, 32'h5A);
        run_slot(3'd6); run_slot(3'd7);

        // Low byte of word 0x10 left untouched by the write
        for (int s = 0; s < 5; s++) run_slot(3'(s));
        b_ack = ack_total;
        cpu_start(1'b0, 20'h00020, 8'h00);
        run_slot(3'd5);
        check("rb_lo_ack", ack_total - b_ack, 1);
        check("rb_lo_rdata", {24'd0, cpu_rdata}, 32'h34);
        run_slot(3'd6); run_slot(3'd7);

        // Request first seen at slot 5 sub>=1: waits for slot 1 (fetch=0)
        for (int s = 0; s < 5; s++) run_slot(3'(s));
        slot = 3'd5;
        tick(); tick();
        b_ack = ack_total;
        cpu_start(1'b0, 20'h00021, 8'h00);
        tick(); tick();
        run_slot(3'd6); run_slot(3'd7);
        fetch = 1'b0;
        run_slot(3'd0);
        check("late_no_ack_yet", ack_total - b_ack, 0);
        run_slot(3'd1);
        check("late_ack_count", ack_total - b_ack, 1);
        check("late_ack_slot", {29'd0, ack_slot}, 32'd1);
        check("late_rdata", {24'd0, ack_rdata}, 32'h5A);
        for (int s = 2; s < 5; s++) run_slot(3'(s));

        // Reset asserted while the write strobe is low
        slot = 3'd5;
        b_ack = ack_total;
        cpu_start(1'b1, 20'h00021, 8'hC3);
        tick();
        ce_24m = 1'b1;
        @(posedge clk_sys); #1;
        check("rstmid_we_low_before", {31'd0, sram_we_n}, 32'h0);
        reset_n = 1'b0;
        #1;
        check("rstmid_strobes", {27'd0, sram_dq_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'h0F);
        ce_24m = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("rstmid_no_ack", ack_total - b_ack, 0);
        check("rstmid_mem_kept", {16'd0, mem[16'h0010]}, 32'h5A34);
        check("rstmid_dout_cleared", {vram_dout1, vram_dout2}, 32'h0);
        reset_n = 1'b1;

        // Normal operation after release
        fetch = 1'b1; vram_addr1 = 19'h00010; vram_addr2 = 19'h06010;
        run_slot(3'd0); run_slot(3'd1); run_slot(3'd2);
        check("post_rst_dout", {vram_dout1, vram_dout2}, 32'h5A34ABCD);
        run_slot(3'd3); run_slot(3'd4);
        b_ack = ack_total;
        cpu_start(1'b0, 20'h00021, 8'h00);
        run_slot(3'd5);
        check("post_rst_ack", ack_total - b_ack, 1);
        check("post_rst_rdata", {24'd0, cpu_rdata}, 32'h5A);
        run_slot(3'd6); run_slot(3'd7);

        check("bus_invariants", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
